// File: rtl/cond_seq_checker_if.sv
// Bus bundle between the gated counter source and cond_seq_checker.
// The master drives the sampled stream and err_clr; the slave returns the checker status.
interface cond_seq_checker_if #(
  parameter int ERR_W = 16
);
  logic             en;
  logic [7:0]       data;
  logic             err_clr;
  logic             locked;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       expected;

  modport master (
    output en, data, err_clr,
    input  locked, mismatch, err_count, expected
  );

  modport slave (
    input  en, data, err_clr,
    output locked, mismatch, err_count, expected
  );
endinterface

// File: rtl/cond_seq_checker.sv
// Lock-and-track checker for a gated free-running 8-bit counter stream.
// Optional COND_CHK_ZERO_CHECK_EN: while locked, nonzero data with en=0 counts as a mismatch.
module cond_seq_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  cond_seq_checker_if.slave bus
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_CNT_C = 4'(LOSS_COUNT);

  logic [1:0]       state_r,     state_s;
  logic [3:0]       match_cnt_r, match_cnt_s;
  logic [3:0]       miss_cnt_r,  miss_cnt_s;
  logic [7:0]       expected_r,  expected_s;
  logic [ERR_W-1:0] err_count_r, err_count_s;
  logic             locked_r;
  logic             mismatch_r;
  logic             err_hit_s;

  logic             data_match_s;
  logic             zero_err_s;
  logic [7:0]       exp_inc_s;
  logic [7:0]       data_inc_s;
  logic [3:0]       match_inc_s;
  logic [3:0]       miss_inc_s;
  logic [ERR_W-1:0] err_base_s;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + ERR_W'(1);
    end
  endfunction

  assign data_match_s = (bus.data == expected_r);
  assign exp_inc_s    = expected_r + 8'd1;
  assign data_inc_s   = bus.data + 8'd1;
  assign match_inc_s  = match_cnt_r + 4'd1;
  assign miss_inc_s   = miss_cnt_r + 4'd1;

`ifdef COND_CHK_ZERO_CHECK_EN
  // A gated source must present zero; anything else while idle is a fault.
  assign zero_err_s = !bus.en && (bus.data != 8'h00);
`else
  assign zero_err_s = 1'b0;
`endif

  // Next-state, counter and expected-value logic.
  always_comb begin
    state_s     = state_r;
    match_cnt_s = match_cnt_r;
    miss_cnt_s  = miss_cnt_r;
    expected_s  = expected_r;
    err_hit_s   = 1'b0;
    case (state_r)
      ST_UNLOCKED: begin
        if (bus.en) begin
          expected_s  = data_inc_s;
          match_cnt_s = 4'd1;
          miss_cnt_s  = 4'd0;
          if (LOCK_CNT_C == 4'd1) begin
            state_s = ST_LOCKED;
          end else begin
            state_s = ST_ACQUIRE;
          end
        end else begin
          state_s = ST_UNLOCKED;
        end
      end
      ST_ACQUIRE: begin
        expected_s = exp_inc_s;
        if (bus.en) begin
          if (data_match_s) begin
            match_cnt_s = match_inc_s;
            if (match_inc_s == LOCK_CNT_C) begin
              state_s    = ST_LOCKED;
              miss_cnt_s = 4'd0;
            end else begin
              state_s = ST_ACQUIRE;
            end
          end else begin
            // Resynchronise on the offending sample instead of dropping out.
            expected_s  = data_inc_s;
            match_cnt_s = 4'd1;
          end
        end else begin
          match_cnt_s = match_cnt_r;
        end
      end
      ST_LOCKED: begin
        // Expected free-runs even after a mismatch; it never resyncs to data here.
        expected_s = exp_inc_s;
        if ((bus.en && !data_match_s) || zero_err_s) begin
          err_hit_s = 1'b1;
          if (miss_inc_s >= LOSS_CNT_C) begin
            state_s     = ST_UNLOCKED;
            match_cnt_s = 4'd0;
            miss_cnt_s  = 4'd0;
          end else begin
            miss_cnt_s = miss_inc_s;
          end
        end else if (bus.en) begin
          miss_cnt_s = 4'd0;
        end else begin
          miss_cnt_s = miss_cnt_r;
        end
      end
      default: begin
        state_s     = ST_UNLOCKED;
        match_cnt_s = 4'd0;
        miss_cnt_s  = 4'd0;
        expected_s  = 8'd0;
      end
    endcase
  end

  // Error counter: clear takes effect before the saturating increment.
  always_comb begin
    if (bus.err_clr) begin
      err_base_s = '0;
    end else begin
      err_base_s = err_count_r;
    end
    if (err_hit_s) begin
      err_count_s = sat_inc(err_base_s);
    end else begin
      err_count_s = err_base_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_UNLOCKED;
      match_cnt_r <= 4'd0;
      miss_cnt_r  <= 4'd0;
      expected_r  <= 8'd0;
      err_count_r <= '0;
      locked_r    <= 1'b0;
      mismatch_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      match_cnt_r <= match_cnt_s;
      miss_cnt_r  <= miss_cnt_s;
      expected_r  <= expected_s;
      err_count_r <= err_count_s;
      locked_r    <= (state_s == ST_LOCKED);
      mismatch_r  <= err_hit_s;
    end
  end

  assign bus.locked    = locked_r;
  assign bus.mismatch  = mismatch_r;
  assign bus.err_count = err_count_r;
  assign bus.expected  = expected_r;

endmodule

// File: tb/tb_cond_seq_checker.sv
// Vector-table and scoreboard bench for cond_seq_checker (default and LOCK_COUNT=1/ERR_W=4 instances).
module tb_cond_seq_checker;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

`ifdef COND_CHK_ZERO_CHECK_EN
  localparam int ZC = 1;
`else
  localparam int ZC = 0;
`endif

  cond_seq_checker_if #(.ERR_W(16)) bus1 ();
  cond_seq_checker_if #(.ERR_W(4))  bus2 ();

  cond_seq_checker #(.LOCK_COUNT(4), .LOSS_COUNT(2), .ERR_W(16)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  cond_seq_checker #(.LOCK_COUNT(1), .LOSS_COUNT(3), .ERR_W(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  typedef struct {
    logic        en;
    logic [7:0]  data;
    logic        clr;
    logic        lk;
    logic        mm;
    logic [15:0] err;
    logic [7:0]  ex;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(int en, int d, int c, int lk, int mm, int err, int ex);
    vec_t v;
    v.en   = en[0];
    v.data = 8'(d);
    v.clr  = c[0];
    v.lk   = lk[0];
    v.mm   = mm[0];
    v.err  = 16'(err);
    v.ex   = 8'(ex);
    return v;
  endfunction

  task automatic check(input string tag, input logic lk, input logic mm,
                       input logic [15:0] err, input logic [7:0] ex, input vec_t e);
    n_vec++;
    if (lk !== e.lk) begin
      n_err++;
      $display("FAIL %s locked: got %0b want %0b", tag, lk, e.lk);
    end
    if (mm !== e.mm) begin
      n_err++;
      $display("FAIL %s mismatch: got %0b want %0b", tag, mm, e.mm);
    end
    if (err !== e.err) begin
      n_err++;
      $display("FAIL %s err_count: got %0h want %0h", tag, err, e.err);
    end
    if (ex !== e.ex) begin
      n_err++;
      $display("FAIL %s expected: got %0h want %0h", tag, ex, e.ex);
    end
  endtask

  task automatic step(input int which, input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    if (which == 1) begin
      bus1.en = v.en; bus1.data = v.data; bus1.err_clr = v.clr;
    end else begin
      bus2.en = v.en; bus2.data = v.data; bus2.err_clr = v.clr;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (which == 1) begin
      check(tag, bus1.locked, bus1.mismatch, bus1.err_count, bus1.expected, e);
    end else begin
      check(tag, bus2.locked, bus2.mismatch, {12'd0, bus2.err_count}, bus2.expected, e);
    end
    if (which == 1) begin
      bus1.en = 1'b0; bus1.data = 8'd0; bus1.err_clr = 1'b0;
    end else begin
      bus2.en = 1'b0; bus2.data = 8'd0; bus2.err_clr = 1'b0;
    end
  endtask

  initial begin
    int e2;
    int sat;
    // lock on 10..13, gap of 5, resume at 19, gap to expected 40
    tbl.push_back(mk(1, 10, 0, 0, 0, 0, 11));
    tbl.push_back(mk(1, 11, 0, 0, 0, 0, 12));
    tbl.push_back(mk(1, 12, 0, 0, 0, 0, 13));
    tbl.push_back(mk(1, 13, 0, 1, 0, 0, 14));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 15 + i));
    tbl.push_back(mk(1, 19, 0, 1, 0, 0, 20));
    for (int i = 0; i < 20; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 21 + i));
    // single corruption, recovery, then two bad samples drop lock
    tbl.push_back(mk(1, 99, 0, 1, 1, 1, 41));
    tbl.push_back(mk(1, 41, 0, 1, 0, 1, 42));
    tbl.push_back(mk(1, 1,  0, 1, 1, 2, 43));
    tbl.push_back(mk(1, 2,  0, 0, 1, 3, 44));
    tbl.push_back(mk(0, 0,  0, 0, 0, 3, 44));
    // wrap through FF -> 00
    tbl.push_back(mk(1, 8'hFD, 0, 0, 0, 3, 8'hFE));
    tbl.push_back(mk(1, 8'hFE, 0, 0, 0, 3, 8'hFF));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 0, 3, 8'h00));
    tbl.push_back(mk(1, 8'h00, 0, 1, 0, 3, 8'h01));
    // err_clr alone, then err_clr with an error
    tbl.push_back(mk(1, 1,     1, 1, 0, 0, 2));
    tbl.push_back(mk(1, 8'h77, 1, 1, 1, 1, 3));
    tbl.push_back(mk(1, 3,     0, 1, 0, 1, 4));
    // idle cycle with nonzero data
    tbl.push_back(mk(0, 5, 0, 1, ZC, 1 + ZC, 5));
    tbl.push_back(mk(1, 5, 0, 1, 0,  1 + ZC, 6));
    tbl.push_back(mk(1, 0, 0, 1, 1,  2 + ZC, 7));
    tbl.push_back(mk(1, 0, 0, 0, 1,  3 + ZC, 8));
    // acquisition with a resync and a gap, no errors counted
    tbl.push_back(mk(1, 50, 0, 0, 0, 3 + ZC, 51));
    tbl.push_back(mk(1, 51, 0, 0, 0, 3 + ZC, 52));
    tbl.push_back(mk(1, 9,  0, 0, 0, 3 + ZC, 10));
    tbl.push_back(mk(1, 10, 0, 0, 0, 3 + ZC, 11));
    tbl.push_back(mk(0, 0,  0, 0, 0, 3 + ZC, 12));
    tbl.push_back(mk(1, 12, 0, 0, 0, 3 + ZC, 13));
    tbl.push_back(mk(1, 13, 0, 1, 0, 3 + ZC, 14));

    reset = 1'b1;
    bus1.en = 1'b0; bus1.data = 8'd0; bus1.err_clr = 1'b0;
    bus2.en = 1'b0; bus2.data = 8'd0; bus2.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset1", bus1.locked, bus1.mismatch, bus1.err_count, bus1.expected, mk(0, 0, 0, 0, 0, 0, 0));
    check("reset2", bus2.locked, bus2.mismatch, {12'd0, bus2.err_count}, bus2.expected, mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(1, tbl[i], $sformatf("vec%0d", i));

    // asynchronous reset while locked with errors pending
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset", bus1.locked, bus1.mismatch, bus1.err_count, bus1.expected, mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    step(1, mk(1, 200, 0, 0, 0, 0, 201), "post_reset_acq");

    // LOCK_COUNT=1 locks on first sample; 4-bit error counter saturation
    step(2, mk(1, 0, 0, 1, 0, 0, 1), "lock1");
    e2 = 1;
    for (int k = 1; k <= 16; k++) begin
      sat = (k > 15) ? 15 : k;
      step(2, mk(1, 8'hAA, 0, 1, 1, sat, e2 + 1), $sformatf("sat_bad%0d", k));
      e2++;
      step(2, mk(1, e2, 0, 1, 0, sat, e2 + 1), $sformatf("sat_good%0d", k));
      e2++;
    end
    step(2, mk(1, 8'hAA, 1, 1, 1, 1, e2 + 1), "clr_with_err");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cond_seq_checker.md
# cond_seq_checker

Receive-side checker for the gated 8-bit free-running counter stream produced by the conditional-output counter block (data = count when en=1, zero when en=0). Locks onto the incrementing sequence, tracks the expected value through enable gaps, since the source counter keeps running while gated, and reports mismatches with a saturating error counter. Sits downstream of the counter block on the same clock, in test and bring-up logic.

## Interface
- LOCK_COUNT, 4: consecutive matching enabled samples, including the first, required to declare lock; legal 1..15.
- LOSS_COUNT, 2: consecutive mismatching enabled samples while locked that drop lock; legal 1..15.
- ERR_W, 16: error counter width.
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- en  input  1  source enable; data is a valid count only when 1.
- data  input  8  gated counter value.
- err_clr  input  1  synchronous clear of err_count.
- locked  output  1  registered; 1 in LOCKED state.
- mismatch  output  1  registered one-cycle pulse per mismatching sample while locked.
- err_count  output  ERR_W  saturating mismatch count.
- expected  output  8  registered expected value for the current cycle.

## Operation
- All outputs reset to 0. State resets to UNLOCKED, match_cnt=0, miss_cnt=0.
- `expected` advances by +1 mod 256 every cycle in ACQUIRE and LOCKED, whether en is high or low. Wrap from 8'hFF to 8'h00 counts as a match.
- UNLOCKED:
  - en=1: expected<=data+1, match_cnt<=1. Go to ACQUIRE, or go directly to LOCKED if LOCK_COUNT==1.
  - en=0: hold.
- ACQUIRE:
  - en=1 and data==expected: match_cnt++. When the new value equals LOCK_COUNT, go to LOCKED with miss_cnt=0.
  - en=1 and data!=expected: resynchronize. expected<=data+1, match_cnt<=1, stay in ACQUIRE.
  - en=0: match_cnt holds; expected still advances.
- LOCKED:
  - en=1 and data==expected: miss_cnt<=0.
  - en=1 and data!=expected: mismatch pulse, err_count+1 (saturates at all-ones), miss_cnt++. When the new value reaches LOSS_COUNT, go to UNLOCKED and clear match_cnt and miss_cnt.
  - After a mismatch, expected keeps free-running from its own value. It does not resync to data.
  - en=0: no check, unless ZERO_CHECK is compiled in (see Configuration); expected advances.
- err_clr and an error in the same cycle: err_count<=1 (the clear applies first, then the increment). err_clr alone: err_count<=0.
- err_count is not cleared by loss of lock; only reset or err_clr clears it.

## Timing
- Sample on cycle N gives state, locked, mismatch and err_count updates visible after edge N+1. Latency is 1 cycle; there is no combinational input-to-output path.
- With LOCK_COUNT=4, locked rises at the edge of the 4th consecutive matching enabled sample.
- Enable gaps of any length inside ACQUIRE or LOCKED do not affect the match or miss counters.
- Reset asserted mid-operation forces all outputs to 0 immediately, without waiting for a clock edge. The first enabled sample after reset release starts acquisition.
- mismatch is never high for more than one cycle per offending sample. Back-to-back errors give back-to-back pulses.

## Configuration
- COND_CHK_ZERO_CHECK_EN defined:
  - While LOCKED, a cycle with en=0 and data!=8'h00 counts as a mismatch: mismatch pulse, err_count+1, miss_cnt++. It can cause loss of lock exactly like an enabled mismatch.
  - A cycle with en=0 and data==8'h00 does not reset miss_cnt.
- Undefined: data is ignored whenever en=0.

## Test plan
- Reset, then en=1 with data 10,11,12,13 -> locked=1 after the 4th edge. expected=14 on the following cycle; err_count=0.
- While locked, en=0 for 5 cycles, then en=1 with data=19 (counter ran on) -> no mismatch, locked stays 1.
- While locked, one corrupted sample (expected 40, data 99) followed by correct data 41 -> single mismatch pulse, err_count=1, locked stays 1. Then two consecutive bad samples -> locked=0 one cycle after the second.
- Sequence 8'hFD,FE,FF,00 from UNLOCKED -> locked=1 with no mismatch, checking the wrap.
- err_count at 16'hFFFF plus a further error -> stays 16'hFFFF. err_clr together with an error -> 1.
- With COND_CHK_ZERO_CHECK_EN, while locked, en=0 and data=8'h05 -> mismatch=1, err_count+1. Without the macro -> no response.
